hyper_mvblck_todram: RTL

// Block mover for the opposite direction to the DRAM-to-LSAB mover: pops a block of words from one

---
 rtl/hyper_mvblck_todram.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/hyper_mvblck_todram.sv
// LSAB-to-DRAM block mover: drains one LSAB section into MCU write beats.
// Optional HYPER_TODRAM_PADMASK_EN drives MCU_WRITE_MASK on pad beats.
module hyper_mvblck_todram #(
  parameter int RD_LEAD  = 2,
  parameter int REL_TAIL = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_lsab_0_empty,
  input  logic        i_lsab_1_empty,
  input  logic        i_lsab_2_empty,
  input  logic        i_lsab_3_empty,
  output logic        o_lsab_read,
  output logic [1:0]  o_lsab_section,
  input  logic [11:0] i_start_address,
  input  logic [5:0]  i_count_req,
  input  logic [1:0]  i_section,
  input  logic [1:0]  i_dram_sel,
  input  logic        i_issue,
  output logic [5:0]  o_count_sent,
  output logic        o_working,
  output logic        o_abrupt_stop,
  output logic [11:0] o_mcu_coll_address,
  output logic        o_mcu_write,
  output logic        o_mcu_write_mask,
  output logic [1:0]  o_mcu_request_access
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRIME = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;
  localparam logic [2:0] LEAD_M1 = 3'(RD_LEAD - 1);
  localparam logic [2:0] TAIL_M1 = 3'(REL_TAIL - 1);

  logic [1:0]  r_state;
  logic [2:0]  r_tmr;
  logic [11:0] r_addr;
  logic [6:0]  r_beat;
  logic [6:0]  r_nbeat;
  logic [5:0]  r_left;
  logic [5:0]  r_sent;
  logic        r_off;
  logic        r_rd_on;
  logic        r_rd_pend;
  logic        r_stop;
  logic        r_abrupt;
  logic [1:0]  r_sec;
  logic [1:0]  r_sel;

  logic [3:0]  w_empty_v;
  logic        w_empty;
  logic        w_want;
  logic        w_pop;
  logic        w_halt;
  logic [6:0]  w_nw;
  logic [6:0]  w_nb_stop;
  logic [6:0]  w_nbeat;
  logic [6:0]  w_req_nw;
  logic [6:0]  w_req_nb;
  logic        w_accept;
  logic        w_beat;
  logic        w_last;

  assign w_empty_v = {i_lsab_3_empty, i_lsab_2_empty,
                      i_lsab_1_empty, i_lsab_0_empty};
  assign w_empty   = w_empty_v[r_sec];
  assign w_want    = r_rd_on & (r_left != 6'd0);
  assign w_pop     = w_want & ~w_empty;
  assign w_halt    = w_want & w_empty;

  // An abrupt stop shrinks the burst to the popped words, padded to even.
  assign w_nw      = {1'b0, r_sent} + {6'd0, r_off};
  assign w_nb_stop = w_nw + {6'd0, w_nw[0]};
  assign w_nbeat   = w_halt ? w_nb_stop : r_nbeat;

  assign w_req_nw  = {1'b0, i_count_req} + {6'd0, i_start_address[0]};
  assign w_req_nb  = w_req_nw + {6'd0, w_req_nw[0]};
  assign w_accept  = (r_state == S_IDLE) & i_issue & (i_count_req != 6'd0);
  assign w_beat    = (r_state == S_WRITE) & (r_beat < w_nbeat);
  assign w_last    = (r_beat + 7'd1) >= w_nbeat;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_tmr     <= '0;
      r_addr    <= '0;
      r_beat    <= '0;
      r_nbeat   <= '0;
      r_left    <= '0;
      r_sent    <= '0;
      r_off     <= 1'b0;
      r_rd_on   <= 1'b0;
      r_rd_pend <= 1'b0;
      r_stop    <= 1'b0;
      r_abrupt  <= 1'b0;
      r_sec     <= '0;
      r_sel     <= '0;
    end else begin
      if (w_pop) begin
        r_sent <= r_sent + 6'd1;
        r_left <= r_left - 6'd1;
      end
      if (w_halt) begin
        r_rd_on <= 1'b0;
        r_stop  <= 1'b1;
        r_nbeat <= w_nb_stop;
      end
      if (r_rd_pend) begin
        r_rd_pend <= 1'b0;
        r_rd_on   <= 1'b1;
      end
      if (w_beat) begin
        r_beat <= r_beat + 7'd1;
        r_addr <= r_addr + 12'd1;
      end
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state   <= S_PRIME;
            r_tmr     <= LEAD_M1;
            r_addr    <= {i_start_address[11:1], 1'b0};
            r_beat    <= '0;
            r_nbeat   <= w_req_nb;
            r_left    <= i_count_req;
            r_sent    <= '0;
            r_off     <= i_start_address[0];
            r_rd_on   <= ~i_start_address[0];
            r_rd_pend <= i_start_address[0];
            r_stop    <= 1'b0;
            r_abrupt  <= 1'b0;
            r_sec     <= i_section;
            r_sel     <= i_dram_sel;
          end
        end
        S_PRIME: begin
          if (r_tmr == 3'd0) begin
            if (w_nbeat != 7'd0) begin
              r_state <= S_WRITE;
            end else begin
              r_state  <= S_DRAIN;
              r_tmr    <= TAIL_M1;
              r_abrupt <= r_stop | w_halt;
            end
          end else begin
            r_tmr <= r_tmr - 3'd1;
          end
        end
        S_WRITE: begin
          if (w_last) begin
            r_state  <= S_DRAIN;
            r_tmr    <= TAIL_M1;
            r_abrupt <= r_stop | w_halt;
          end
        end
        S_DRAIN: begin
          if (r_tmr == 3'd0) begin
            r_state <= S_IDLE;
          end else begin
            r_tmr <= r_tmr - 3'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_mcu_request_access = 2'b00;
    unique case (r_state)
      S_IDLE:  o_mcu_request_access = i_dram_sel & {2{i_issue & i_rst_n}};
      S_PRIME: o_mcu_request_access = (w_nbeat != 7'd0) ? r_sel : 2'b00;
      S_WRITE: o_mcu_request_access =
                 ((r_beat + 7'd1) < w_nbeat) ? r_sel : 2'b00;
      default: o_mcu_request_access = 2'b00;
    endcase
  end

`ifdef HYPER_TODRAM_PADMASK_EN
  // A beat carries no word if it precedes the data or lies past the last pop.
  logic w_pad;
  assign w_pad = (r_beat == 7'd0 && r_off) |
                 (r_beat >= ({1'b0, r_sent} + {6'd0, r_off}));
  assign o_mcu_write_mask = w_beat & w_pad;
`else
  assign o_mcu_write_mask = 1'b0;
`endif

  assign o_lsab_read        = w_pop;
  assign o_lsab_section     = r_sec;
  assign o_count_sent       = r_sent;
  assign o_working          = (r_state != S_IDLE);
  assign o_abrupt_stop      = r_abrupt;
  assign o_mcu_coll_address = r_addr;
  assign o_mcu_write        = w_beat;

endmodule
